// File: rtl/grf_dump_pkg.sv
// Shared types and default geometry for the GRF dump reader.
// The dump FSM states and the register-file dimensions used as parameter defaults.
package grf_dump_pkg;

    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = 5;
    localparam int DW_DEFAULT   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/grf_dirty_tracker.sv
// Dirty bitmap for the GRF: snooped writes set bits, captures clear them.
// A set and a clear of the same bit in one cycle leave the bit set; bit 0 is never dirty.
module grf_dirty_tracker
    import grf_dump_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] dirty
);

    logic [NREG-1:0] dirty_nxt_s;

    // Next bitmap: set has priority over clear so a write racing a capture is not lost.
    always_comb begin
        dirty_nxt_s = dirty;
        for (int i = 0; i < NREG; i++) begin
            if (set_en && (set_addr == AW'(i))) begin
                dirty_nxt_s[i] = 1'b1;
            end else if (clr_en && (clr_addr == AW'(i))) begin
                dirty_nxt_s[i] = 1'b0;
            end else begin
                dirty_nxt_s[i] = dirty[i];
            end
        end
        dirty_nxt_s[0] = 1'b0;
    end

    // Bitmap register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dirty <= {NREG{1'b0}};
        end else begin
            dirty <= dirty_nxt_s;
        end
    end

endmodule

// File: rtl/grf_dump_reader.sv
// Walks the GRF through one read port and streams {index, value} entries on a valid/ready port.
// Optionally restricts the dump to registers written since they were last captured.
module grf_dump_reader
    import grf_dump_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dirty_only,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    input  logic          wr_snoop_en,
    input  logic [AW-1:0] wr_snoop_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data
);

    dump_state_t     state_r;
    logic [AW-1:0]   idx_r;
    logic            dirty_only_r;
    logic [NREG-1:0] dirty_s;
    logic            capture_s;
    logic            last_s;

    // The scan index is itself the GRF read address, so rd_data always reflects idx_r.
    assign rd_addr = idx_r;

    grf_dirty_tracker #(
        .NREG (NREG),
        .AW   (AW)
    ) u_dirty (
        .clk      (clk),
        .reset    (reset),
        .set_en   (wr_snoop_en),
        .set_addr (wr_snoop_addr),
        .clr_en   (capture_s),
        .clr_addr (idx_r),
        .dirty    (dirty_s)
    );

    // Capture decision for the register under the scan pointer.
    always_comb begin
        last_s = (idx_r == AW'(NREG - 1));
        if (state_r == SCAN) begin
            capture_s = !dirty_only_r || dirty_s[idx_r];
        end else begin
            capture_s = 1'b0;
        end
    end

    // Dump FSM with scan counter and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= {AW{1'b0}};
            dirty_only_r <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            out_idx      <= {AW{1'b0}};
            out_data     <= {DW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dirty_only_r <= dirty_only;
                        idx_r        <= {AW{1'b0}};
                        busy         <= 1'b1;
                        state_r      <= SCAN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (capture_s) begin
                        out_data  <= rd_data;
                        out_idx   <= idx_r;
                        out_valid <= 1'b1;
                        state_r   <= HOLD;
                    end else if (last_s) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + AW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_s) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            idx_r   <= idx_r + AW'(1);
                            state_r <= SCAN;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grf_dump_reader.sv
// Self-checking bench for grf_dump_reader with a behavioural GRF and a dirty-set/register model.
// Expected entry lists and done timing are derived from the model, never from the DUT.
module tb_grf_dump_reader;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        reset, start, dirty_only, busy, done;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    logic [31:0] regs [NREG];
    logic [31:0] mregs [NREG];
    bit          md [NREG];

    int          exp_idx[$];
    logic [31:0] exp_dat[$];
    int          got_idx[$];
    logic [31:0] got_dat[$];
    int          done_cyc;
    logic        post_busy, post_done;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    grf_dump_reader dut (
        .clk(clk), .reset(reset), .start(start), .dirty_only(dirty_only),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_snoop_en(wr_en), .wr_snoop_addr(wr_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
    );

    // Behavioural GRF: combinational read, r0 hard-wired to zero.
    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];
    always @(posedge clk) if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
        step;
        wr_en = 1'b0;
        if (a != 0) begin mregs[a] = d; md[a] = 1'b1; end
    endtask

    task automatic build_exp(input bit donly);
        exp_idx.delete(); exp_dat.delete();
        for (int i = 0; i < NREG; i++)
            if (!donly || md[i]) begin exp_idx.push_back(i); exp_dat.push_back(mregs[i]); end
    endtask

    task automatic retire_exp;
        foreach (exp_idx[i]) md[exp_idx[i]] = 1'b0;
    endtask

    // Runs one dump; done_cyc counts from the cycle start was asserted (-1 on timeout).
    task automatic run_dump(input bit donly, input bit rand_ready, input bit poke_done);
        logic rdy;
        got_idx.delete(); got_dat.delete();
        done_cyc = -1;
        start = 1'b1; dirty_only = donly;
        step;
        start = 1'b0; dirty_only = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done) begin done_cyc = c + 1; break; end
            rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = rdy;
            if (out_valid && rdy) begin got_idx.push_back(int'(out_idx)); got_dat.push_back(out_data); end
            step;
        end
        out_ready = 1'b1;
        start = poke_done;
        step;
        start = 1'b0;
        post_busy = busy; post_done = done;
        step;
        post_busy = post_busy | busy;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; dirty_only = 1'b0; wr_en = 1'b0; wr_addr = 5'd0;
        wr_data = 32'd0; out_ready = 1'b1;
        step; step;
        nvec++;
        if ({busy, done, out_valid} !== 3'b000 || out_idx !== 5'd0 || out_data !== 32'd0 || rd_addr !== 5'd0) begin
            nerr++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b idx=%0d data=%h rd_addr=%0d, required all 0",
                     busy, done, out_valid, out_idx, out_data, rd_addr);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_dirty_basic;
        wr(2, 32'd16499);
        wr(5, 32'd165464);
        build_exp(1'b1);
        run_dump(1'b1, 1'b0, 1'b0);
        nvec++;
        if (got_idx.size() != exp_idx.size()) begin
            nerr++; $display("FAIL dirty_basic_count: got %0d entries, required %0d", got_idx.size(), exp_idx.size());
        end
        for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
            nvec++;
            if (got_idx[i] != exp_idx[i] || got_dat[i] !== exp_dat[i]) begin
                nerr++; $display("FAIL dirty_basic_entry%0d: got (%0d,%0d), required (%0d,%0d)",
                                 i, got_idx[i], got_dat[i], exp_idx[i], exp_dat[i]);
            end
        end
        nvec++;
        if (done_cyc != NREG + 1 + exp_idx.size()) begin
            nerr++; $display("FAIL dirty_basic_done: done at cycle %0d, required %0d", done_cyc, NREG + 1 + exp_idx.size());
        end
        nvec++;
        if (post_busy !== 1'b0 || post_done !== 1'b0) begin
            nerr++; $display("FAIL dirty_basic_idle: busy=%b done=%b after dump, required 0 0", post_busy, post_done);
        end
        retire_exp();
    endtask

    task automatic test_dirty_empty;
        build_exp(1'b1);
        run_dump(1'b1, 1'b0, 1'b1);
        nvec++;
        if (got_idx.size() != 0) begin
            nerr++; $display("FAIL empty_count: got %0d entries, required 0", got_idx.size());
        end
        nvec++;
        if (done_cyc != NREG + 1) begin
            nerr++; $display("FAIL empty_done: done at cycle %0d, required %0d", done_cyc, NREG + 1);
        end
        nvec++;
        if (post_busy !== 1'b0 || post_done !== 1'b0) begin
            nerr++; $display("FAIL start_in_done: busy=%b done=%b after start in DONE, required 0 0", post_busy, post_done);
        end
    endtask

    task automatic test_full_dump;
        for (int k = 0; k < 8; k++) wr($urandom_range(0, NREG - 1), $urandom);
        build_exp(1'b0);
        run_dump(1'b0, 1'b0, 1'b0);
        nvec++;
        if (got_idx.size() != NREG) begin
            nerr++; $display("FAIL full_count: got %0d entries, required %0d", got_idx.size(), NREG);
        end
        for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
            nvec++;
            if (got_idx[i] != exp_idx[i] || got_dat[i] !== exp_dat[i]) begin
                nerr++; $display("FAIL full_entry%0d: got (%0d,%h), required (%0d,%h)",
                                 i, got_idx[i], got_dat[i], exp_idx[i], exp_dat[i]);
            end
        end
        nvec++;
        if (done_cyc != 2 * NREG + 1) begin
            nerr++; $display("FAIL full_done: done at cycle %0d, required %0d", done_cyc, 2 * NREG + 1);
        end
        retire_exp();
    endtask

    task automatic test_random_dumps;
        bit donly;
        for (int it = 0; it < 6; it++) begin
            for (int k = $urandom_range(0, 6); k > 0; k--) wr($urandom_range(0, NREG - 1), $urandom);
            donly = ($urandom_range(0, 2) != 0);
            build_exp(donly);
            run_dump(donly, 1'b1, 1'b0);
            nvec++;
            if (got_idx.size() != exp_idx.size() || done_cyc < 0) begin
                nerr++; $display("FAIL random%0d_count: got %0d entries done=%0d, required %0d entries",
                                 it, got_idx.size(), done_cyc, exp_idx.size());
            end
            for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
                nvec++;
                if (got_idx[i] != exp_idx[i] || got_dat[i] !== exp_dat[i]) begin
                    nerr++; $display("FAIL random%0d_entry%0d: got (%0d,%h), required (%0d,%h)",
                                     it, i, got_idx[i], got_dat[i], exp_idx[i], exp_dat[i]);
                end
            end
            retire_exp();
        end
    endtask

    task automatic test_hold_write;
        bit held = 1'b0;
        int bad = 0;
        wr(3, 32'hA5A5_0003);
        build_exp(1'b0);
        got_idx.delete(); got_dat.delete();
        start = 1'b1; step; start = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            if (out_valid && out_idx == 5'd3 && !held) begin
                held = 1'b1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    wr_en = (k == 2); wr_addr = 5'd3; wr_data = 32'd7;
                    step;
                    wr_en = 1'b0;
                    if (out_valid !== 1'b1 || out_idx !== 5'd3 || out_data !== exp_dat[3]) bad++;
                end
                out_ready = 1'b1;
            end
            if (out_valid) begin got_idx.push_back(int'(out_idx)); got_dat.push_back(out_data); end
            step;
        end
        nvec++;
        if (!held || bad != 0) begin
            nerr++; $display("FAIL hold_stable: held=%b unstable_cycles=%0d, required held=1 unstable=0", held, bad);
        end
        nvec++;
        if (got_idx.size() != NREG || got_dat[3] !== exp_dat[3]) begin
            nerr++; $display("FAIL hold_entries: got %0d entries, required %0d with r3=%h", got_idx.size(), NREG, exp_dat[3]);
        end
        step;
        retire_exp();
        mregs[3] = 32'd7; md[3] = 1'b1;
        build_exp(1'b1);
        run_dump(1'b1, 1'b0, 1'b0);
        nvec++;
        if (got_idx.size() != exp_idx.size() || got_idx.size() == 0 || got_idx[0] != exp_idx[0] || got_dat[0] !== exp_dat[0]) begin
            nerr++; $display("FAIL hold_dirty_after: got %0d entries first=(%0d,%0d), required (3,7) only",
                             got_idx.size(), got_idx.size() ? got_idx[0] : -1, got_idx.size() ? got_dat[0] : 32'd0);
        end
        retire_exp();
    endtask

    task automatic test_same_cycle_write;
        bit wrote = 1'b0;
        wr(9, 32'h0000_1234);
        build_exp(1'b0);
        got_idx.delete(); got_dat.delete();
        start = 1'b1; step; start = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            if (busy && !out_valid && rd_addr == 5'd9 && !wrote) begin
                wrote = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
            end
            if (out_valid) begin got_idx.push_back(int'(out_idx)); got_dat.push_back(out_data); end
            step;
            wr_en = 1'b0;
        end
        nvec++;
        if (got_idx.size() != NREG || got_dat[9] !== exp_dat[9]) begin
            nerr++; $display("FAIL race_old_value: got %0d entries r9=%h, required %0d entries r9=%h",
                             got_idx.size(), got_idx.size() > 9 ? got_dat[9] : 32'd0, NREG, exp_dat[9]);
        end
        step;
        retire_exp();
        mregs[9] = 32'h55; md[9] = 1'b1;
        build_exp(1'b1);
        run_dump(1'b1, 1'b0, 1'b0);
        nvec++;
        if (got_idx.size() != exp_idx.size() || got_idx.size() == 0 || got_idx[0] != exp_idx[0] || got_dat[0] !== exp_dat[0]) begin
            nerr++; $display("FAIL race_dirty_kept: got %0d entries, required (9,0x55) only", got_idx.size());
        end
        retire_exp();
    endtask

    task automatic test_reset_mid_dump;
        bit reached = 1'b0;
        int late_done = 0;
        got_idx.delete(); got_dat.delete();
        start = 1'b1; step; start = 1'b0;
        for (int c = 0; c < 500 && !reached; c++) begin
            start = (c == 5);
            if (out_valid && out_idx == 5'd10) begin reached = 1'b1; out_ready = 1'b0; end
            else begin
                if (out_valid) begin got_idx.push_back(int'(out_idx)); got_dat.push_back(out_data); end
                step;
            end
        end
        start = 1'b0;
        nvec++;
        if (!reached || got_idx.size() != 10 || got_idx[9] != 9) begin
            nerr++; $display("FAIL mid_start_ignored: reached=%b entries=%0d, required reached=1 entries=10 ending at 9",
                             reached, got_idx.size());
        end
        reset = 1'b1;
        step;
        nvec++;
        if ({out_valid, busy, done} !== 3'b000 || out_idx !== 5'd0 || out_data !== 32'd0) begin
            nerr++; $display("FAIL reset_abort: valid=%b busy=%b done=%b idx=%0d data=%h, required all 0",
                             out_valid, busy, done, out_idx, out_data);
        end
        step;
        reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) late_done++;
            step;
        end
        nvec++;
        if (late_done != 0) begin
            nerr++; $display("FAIL reset_no_done: %0d cycles with busy/done after abort, required 0", late_done);
        end
        for (int i = 0; i < NREG; i++) md[i] = 1'b0;
        build_exp(1'b1);
        run_dump(1'b1, 1'b0, 1'b0);
        nvec++;
        if (got_idx.size() != exp_idx.size() || done_cyc != NREG + 1) begin
            nerr++; $display("FAIL reset_bitmap_clear: got %0d entries done=%0d, required 0 entries done=%0d",
                             got_idx.size(), done_cyc, NREG + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin regs[i] = 32'd0; mregs[i] = 32'd0; md[i] = 1'b0; end
        test_reset();
        test_dirty_basic();
        test_dirty_empty();
        test_full_dump();
        test_random_dumps();
        test_hold_write();
        test_same_cycle_write();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
